// File: rtl/pi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : pi_cmd_receiver
// Brief    : Raspberry Pi serial command receiver; validates 16-bit frames and
//            updates the chip-control registers in the CLK domain.
// Revision : 1.0 - initial release
// ============================================================================
module pi_cmd_receiver #(
  parameter int           SYNC_STAGES = 2,
  parameter int           ERR_CNT_W   = 8,
  parameter logic [1:0]   RST_CLK_CTL = 2'b10,
  parameter logic [1:0]   RST_K       = 2'b11
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pi_clk,
  input  logic                 pi_data,
  input  logic                 pi_load,
  output logic [1:0]           clk_ctl,
  output logic [1:0]           k0,
  output logic [1:0]           k1,
  output logic [1:0]           c_sel,
  output logic [1:0]           enable,
  output logic [1:0]           dat_ctl,
  output logic                 soft_rst,
  output logic                 cmd_ack,
  output logic                 cmd_ok,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [4:0] C_FRAME_BITS = 5'd16;
  localparam logic [4:0] C_CNT_SAT    = 5'd17;
  localparam logic [3:0] C_MAX_ADDR   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_clk_dly;
  logic                   r_load_dly;

  logic [15:0]            r_shift;
  logic [4:0]             r_bit_cnt;
  logic [1:0]             r_clk_ctl;
  logic [1:0]             r_k0;
  logic [1:0]             r_k1;
  logic [1:0]             r_c_sel;
  logic [1:0]             r_enable;
  logic [1:0]             r_dat_ctl;
  logic                   r_soft_rst;
  logic                   r_cmd_ack;
  logic                   r_cmd_ok;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic       w_clk_s;
  logic       w_data_s;
  logic       w_load_s;
  logic       w_clk_rise;
  logic       w_load_rise;
  logic       w_shift_en;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic       w_accept;

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s    = r_data_sync[SYNC_STAGES-1];
  assign w_load_s    = r_load_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_clk_s & ~r_clk_dly;
  assign w_load_rise = w_load_s & ~r_load_dly;

  assign w_addr   = r_shift[15:12];
  assign w_data   = r_shift[11:4];
  assign w_accept = (r_bit_cnt == C_FRAME_BITS) && !(^r_shift) &&
                    (r_shift[3:1] == 3'b000) && (w_addr <= C_MAX_ADDR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_load_sync <= '0;
      r_clk_dly   <= 1'b0;
      r_load_dly  <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], pi_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], pi_data};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], pi_load};
      r_clk_dly   <= w_clk_s;
      r_load_dly  <= w_load_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A load edge always beats a coincident clock edge; in IDLE it is simply ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_load_rise && w_clk_rise) begin
          w_state_nxt = S_SHIFT;
          w_shift_en  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_load_rise) begin
          w_state_nxt = S_CHECK;
        end else if (w_clk_rise) begin
          w_shift_en  = 1'b1;
        end
      end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_clk_ctl  <= RST_CLK_CTL;
      r_k0       <= RST_K;
      r_k1       <= RST_K;
      r_c_sel    <= '0;
      r_enable   <= '0;
      r_dat_ctl  <= '0;
      r_soft_rst <= 1'b0;
      r_cmd_ack  <= 1'b0;
      r_cmd_ok   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_soft_rst <= 1'b0;
      r_cmd_ack  <= 1'b0;
      if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_data_s};
        if (r_bit_cnt != C_CNT_SAT) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (r_state == S_CHECK) begin
        r_bit_cnt <= '0;
        if (w_accept) begin
          r_cmd_ack <= 1'b1;
          r_cmd_ok  <= 1'b1;
          case (w_addr)
            4'd0: r_clk_ctl <= w_data[1:0];
            4'd1: begin
              r_k0 <= w_data[1:0];
              r_k1 <= w_data[3:2];
            end
            4'd2: r_c_sel <= w_data[1:0];
            4'd3: begin
              r_enable  <= w_data[1:0];
              r_dat_ctl <= w_data[3:2];
            end
            default: r_soft_rst <= 1'b1;
          endcase
        end else begin
          r_cmd_ok <= 1'b0;
          if (r_err_cnt != {ERR_CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign clk_ctl  = r_clk_ctl;
  assign k0       = r_k0;
  assign k1       = r_k1;
  assign c_sel    = r_c_sel;
  assign enable   = r_enable;
  assign dat_ctl  = r_dat_ctl;
  assign soft_rst = r_soft_rst;
  assign cmd_ack  = r_cmd_ack;
  assign cmd_ok   = r_cmd_ok;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_cmd_receiver
// Brief    : Directed self-checking bench for pi_cmd_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_cmd_receiver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       pi_clk = 1'b0;
  logic       pi_data = 1'b0;
  logic       pi_load = 1'b0;
  logic [1:0] clk_ctl, k0, k1, c_sel, enable, dat_ctl;
  logic       soft_rst, cmd_ack, cmd_ok;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int ack_cnt;
  int srst_cnt;

  pi_cmd_receiver #(
    .SYNC_STAGES(2),
    .ERR_CNT_W  (8),
    .RST_CLK_CTL(2'b10),
    .RST_K      (2'b11)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .pi_clk  (pi_clk),
    .pi_data (pi_data),
    .pi_load (pi_load),
    .clk_ctl (clk_ctl),
    .k0      (k0),
    .k1      (k1),
    .c_sel   (c_sel),
    .enable  (enable),
    .dat_ctl (dat_ctl),
    .soft_rst(soft_rst),
    .cmd_ack (cmd_ack),
    .cmd_ok  (cmd_ok),
    .err_cnt (err_cnt)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled on the falling edge, cleared while in reset.
  always @(negedge CLK) begin
    if (RST) begin
      ack_cnt  <= 0;
      srst_cnt <= 0;
    end else begin
      if (cmd_ack)  ack_cnt  <= ack_cnt + 1;
      if (soft_rst) srst_cnt <= srst_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    pi_clk  = 1'b0;
    pi_data = 1'b0;
    pi_load = 1'b0;
    RST     = 1'b1;
    wait_clk(4);
    RST     = 1'b0;
    wait_clk(2);
  endtask

  task automatic pi_bit(input logic b);
    pi_data = b;
    wait_clk(3);
    pi_clk = 1'b1;
    wait_clk(3);
    pi_clk = 1'b0;
    wait_clk(1);
  endtask

  task automatic send_bits(input logic [15:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) pi_bit(f[15-i]);
  endtask

  task automatic do_load();
    pi_load = 1'b1;
    wait_clk(3);
    pi_load = 1'b0;
    wait_clk(8);
  endtask

  initial begin
    do_reset();
    wait_clk(20);
    chk("rst_clk_ctl", 32'(clk_ctl), 32'h2);
    chk("rst_k0",      32'(k0),      32'h3);
    chk("rst_k1",      32'(k1),      32'h3);
    chk("rst_c_sel",   32'(c_sel),   32'h0);
    chk("rst_enable",  32'(enable),  32'h0);
    chk("rst_dat_ctl", 32'(dat_ctl), 32'h0);
    chk("rst_err",     32'(err_cnt), 32'h0);
    chk("rst_ok",      32'(cmd_ok),  32'h0);

    do_load();
    chk("idle_load_err", 32'(err_cnt), 32'h0);
    chk("idle_load_ack", 32'(ack_cnt), 32'h0);

    send_bits(16'h1061, 16); do_load();
    chk("k_k0",  32'(k0),      32'h2);
    chk("k_k1",  32'(k1),      32'h1);
    chk("k_ack", 32'(ack_cnt), 32'h1);
    chk("k_ok",  32'(cmd_ok),  32'h1);
    chk("k_err", 32'(err_cnt), 32'h0);

    send_bits(16'h1060, 16); do_load();
    chk("par_k0",  32'(k0),      32'h2);
    chk("par_k1",  32'(k1),      32'h1);
    chk("par_ok",  32'(cmd_ok),  32'h0);
    chk("par_err", 32'(err_cnt), 32'h1);
    chk("par_ack", 32'(ack_cnt), 32'h1);

    send_bits(16'h2031, 16); do_load();
    chk("csel", 32'(c_sel), 32'h3);
    send_bits(16'h30E1, 16); do_load();
    chk("en_enable",  32'(enable),  32'h2);
    chk("en_dat_ctl", 32'(dat_ctl), 32'h3);
    chk("en_ack",     32'(ack_cnt), 32'h3);
    send_bits(16'h0012, 16); do_load();
    chk("resv_err",   32'(err_cnt), 32'h2);
    chk("resv_clk",   32'(clk_ctl), 32'h2);

    do_reset();
    send_bits(16'h0011, 15); do_load();
    send_bits(16'h0011, 16); pi_bit(1'b0); do_load();
    chk("len_err", 32'(err_cnt), 32'h2);
    chk("len_clk", 32'(clk_ctl), 32'h2);
    chk("len_ok",  32'(cmd_ok),  32'h0);
    send_bits(16'h0011, 16); do_load();
    chk("cc_clk", 32'(clk_ctl), 32'h1);
    chk("cc_ok",  32'(cmd_ok),  32'h1);

    send_bits(16'h4001, 16); do_load();
    chk("srst_pulse", 32'(srst_cnt), 32'h1);
    chk("srst_ack",   32'(ack_cnt),  32'h2);
    chk("srst_clk",   32'(clk_ctl),  32'h1);
    chk("srst_k0",    32'(k0),       32'h3);
    send_bits(16'h5000, 16); do_load();
    chk("a5_err", 32'(err_cnt), 32'h3);
    chk("a5_ok",  32'(cmd_ok),  32'h0);
    chk("a5_srst", 32'(srst_cnt), 32'h1);

    do_reset();
    send_bits(16'h1061, 8);
    do_reset();
    chk("mid_k0", 32'(k0), 32'h3);
    send_bits(16'h0011, 16); do_load();
    chk("mid_clk", 32'(clk_ctl), 32'h1);
    chk("mid_ok",  32'(cmd_ok),  32'h1);
    chk("mid_err", 32'(err_cnt), 32'h0);

    for (int i = 0; i < 255; i++) begin
      pi_bit(1'b1);
      do_load();
    end
    chk("sat_255", 32'(err_cnt), 32'hFF);
    for (int i = 0; i < 45; i++) begin
      pi_bit(1'b1);
      do_load();
    end
    chk("sat_hold", 32'(err_cnt), 32'hFF);
    chk("sat_clk",  32'(clk_ctl), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pi_cmd_receiver.md
Name: pi_cmd_receiver

Overview:
- Raspberry Pi to FPGA serial command receiver. It is the write-direction counterpart of the FPGA to Pi shift-out data path.
- The Pi shifts a 16-bit frame in on pi_clk/pi_data, then strobes pi_load.
- The block validates the frame and updates the chip-control registers: clock-gen select, K, C, enables and data pattern. These registers drive the test-chip pins and CLK_GEN_TOP.
- Runs in the CLK domain. All Pi inputs are asynchronous.

Parameters:
SYNC_STAGES, 2, synchronizer depth on pi_clk/pi_data/pi_load (min 2)
ERR_CNT_W, 8, width of rejected-frame counter (saturating)
RST_CLK_CTL, 2'b10, reset value of clk_ctl
RST_K, 2'b11, reset value of k0/k1 (EXT_CLK)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
pi_clk  in  1  Pi serial clock, async; data sampled on its rising edge
pi_data  in  1  Pi serial data, async, MSB first
pi_load  in  1  Pi frame strobe, async; rising edge ends frame
clk_ctl  out  2  CLK_GEN_TOP clock select
k0  out  2  chip0 clock-gen control
k1  out  2  chip1 clock-gen control
c_sel  out  2  RO frequency control (C0/C1)
enable  out  2  {enable1,enable0}; 0=EXT, 1=INT
dat_ctl  out  2  DUT data pattern select
soft_rst  out  1  one-cycle pulse on command addr 4
cmd_ack  out  1  one-cycle pulse on accepted write
cmd_ok  out  1  level: result of the last frame (1=accepted)
err_cnt  out  ERR_CNT_W  count of rejected frames

Behaviour:
- Frame format (bit 15 first):
  - [15:12] addr
  - [11:4] data
  - [3:1] reserved, must be 000
  - [0] even parity over [15:1], so the total number of 1s in the frame is even.
- Register map (only the listed data bits are used):
  - addr0: clk_ctl=data[1:0]
  - addr1: k0=data[1:0], k1=data[3:2]
  - addr2: c_sel=data[1:0]
  - addr3: enable=data[1:0], dat_ctl=data[3:2]
  - addr4: soft_rst pulse, data ignored
  - addr 5..15: invalid.
- Synchronizers: each async input passes through SYNC_STAGES flops. A rising edge is detected on the synchronized signal by comparing it with one extra delay flop.
- FSM states:
  - IDLE: bit_cnt=0.
  - SHIFT: on each pi_clk rise, shift_reg <= {shift_reg[14:0], pi_data_sync}; bit_cnt increments and saturates at 17.
  - CHECK: one cycle; evaluate the frame, update outputs, return to IDLE with bit_cnt cleared.
- Transitions:
  - IDLE to SHIFT on the first pi_clk rise.
  - SHIFT to CHECK on a pi_load rise.
  - IDLE plus a pi_load rise with bit_cnt=0: ignored, no error, cmd_ok unchanged.
- Accept condition: bit_cnt==16, parity ok, reserved==000, addr<=4.
  - On accept: write the register (or pulse soft_rst), pulse cmd_ack, set cmd_ok=1.
  - On anything else: no register change, cmd_ok=0, err_cnt+1 (saturating at all-ones). Short frames, long frames (>16 bits), bad parity, nonzero reserved and bad addr are all rejected this way.
- Latency: the registers, cmd_ack, soft_rst, cmd_ok and err_cnt all update in the same CLK edge that leaves CHECK. That is the second CLK after the synchronized pi_load edge is detected.
- A pi_clk rise and a pi_load rise detected in the same cycle: load wins and that clock edge's bit is discarded.
- pi_clk edges arriving during CHECK are dropped.
- Reset values, any state, reset overrides everything:
  - clk_ctl=RST_CLK_CTL, k0=k1=RST_K
  - c_sel=0, enable=0, dat_ctl=0
  - soft_rst=0, cmd_ack=0, cmd_ok=0, err_cnt=0
  - shift_reg=0, bit_cnt=0, FSM=IDLE, synchronizer flops=0.
- Reset asserted mid-frame discards the partial frame. After reset the next frame starts fresh.
- soft_rst does not reset this block. The top level ORs it into the design reset of the other blocks.

Test Plan:
- Reset, then idle 20 cycles → clk_ctl=10, k0=k1=11, c_sel=0, enable=0, dat_ctl=0, err_cnt=0, cmd_ok=0.
- Shift 0x1061 then load → k0=10, k1=01, exactly one cmd_ack pulse, cmd_ok=1, err_cnt=0.
- Shift 0x1060 (bad parity) then load → k0/k1 unchanged, cmd_ok=0, err_cnt=1, no cmd_ack.
- Shift 15 bits of 0x0011, load; then 17 bits (0x0011 plus one extra bit), load → both rejected, err_cnt=2, clk_ctl unchanged. Then 0x0011, load → clk_ctl=01, cmd_ok=1.
- Shift 0x4001 then load → soft_rst high for exactly 1 cycle, other registers unchanged. Also shift 0x5000 (addr5, even parity) then load → rejected, err_cnt+1.
- Mid-frame RST after 8 bits, then a full 0x0011 frame and load → accepted, clk_ctl=01. Separately, 300 bad frames → err_cnt holds at 255.
